// File: rtl/traffic_gen_pkg.sv
// Op codes and FSM state encoding shared by the traffic generator files.
package traffic_gen_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_INIT  = 3'd5;
   localparam logic [2:0] OP_FILL  = 3'd6;
   localparam logic [2:0] OP_START = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/traffic_gen_if.sv
// Command bus in, flit stream and status out; master drives commands and credits.
interface traffic_gen_if #(
   parameter int DEST_W = 14,
   parameter int VC_W   = 2,
   parameter int DATA_W = 32
);
   localparam int NUM_VC = 1 << VC_W;
   localparam int FLIT_W = 2 + VC_W + DEST_W;

   logic [2:0]        op;
   logic [DATA_W-1:0] data;
   logic [NUM_VC-1:0] credit_in;
   logic              flit_valid;
   logic [FLIT_W-1:0] flit_data;
   logic              done;
   logic              err;

   modport master (
      output op, data, credit_in,
      input  flit_valid, flit_data, done, err
   );

   modport slave (
      input  op, data, credit_in,
      output flit_valid, flit_data, done, err
   );

endinterface

// File: rtl/traffic_gen_credit_ctr.sv
// Per-VC downstream credit counter: starts full, -1 on emit, +1 on return, saturates at max.
// Combinational has_credit/overflow; count updates on the next edge.
module traffic_gen_credit_ctr #(
   parameter int CREDIT_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic dec,
   input  logic inc,
   output logic has_credit,
   output logic overflow
);
   localparam int CW = $clog2(CREDIT_MAX + 1);

   logic [CW-1:0] cnt;

   assign has_credit = cnt != '0;
   assign overflow   = inc && !dec && (cnt == CW'(CREDIT_MAX));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= CW'(CREDIT_MAX);
      end else if (inc && !dec) begin
         if (!overflow)
            cnt <= cnt + CW'(1);
      end else if (dec && !inc) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/traffic_gen.sv
// NoC traffic source: replays stored descriptors as flits, one flit per cycle when the VC has credit,
// 1-cycle decision-to-flit latency; zero credit stalls in place. TRAFFIC_STATS_EN adds stat counters.
module traffic_gen
   import traffic_gen_pkg::*;
#(
   parameter int DEST_W     = 14,
   parameter int VC_W       = 2,
   parameter int NFLIT_W    = 10,
   parameter int DEPTH      = 1024,
   parameter int CNT_W      = 10,
   parameter int DATA_W     = 32,
   parameter int CREDIT_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   traffic_gen_if.slave bus
`ifdef TRAFFIC_STATS_EN
   ,
   output logic [31:0] stat_flits,
   output logic [31:0] stat_stall
`endif
);
   localparam int NUM_VC = 1 << VC_W;
   localparam int AW     = $clog2(DEPTH);
   localparam int DESC_W = NFLIT_W + VC_W + DEST_W;

   state_t             state;
   logic [CNT_W-1:0]   total;
   logic [CNT_W-1:0]   sent;
   logic [AW:0]        fill_cnt;
   logic [AW-1:0]      head;
   logic [NFLIT_W-1:0] flit_idx;
   logic [DESC_W-1:0]  desc_mem [DEPTH];

   logic               is_init, is_fill, is_start, fill_ok;
   logic               emit, is_tail, last_pkt, head_wrap;
   logic [DEST_W-1:0]  cur_dest;
   logic [VC_W-1:0]    cur_vc;
   logic [NFLIT_W-1:0] cur_nf, fill_nf;
   logic [NUM_VC-1:0]  has_credit, credit_dec, credit_ovf;

   assign is_init  = bus.op == OP_INIT;
   assign is_fill  = bus.op == OP_FILL;
   assign is_start = bus.op == OP_START;
   assign fill_ok  = is_fill && (state == ST_LOAD) && (fill_cnt != (AW+1)'(DEPTH));

   // A zero flit count would never produce a tail, so it is stored as a single-flit packet.
   assign fill_nf = (bus.data[DEST_W+VC_W +: NFLIT_W] == '0) ? NFLIT_W'(1)
                                                             : bus.data[DEST_W+VC_W +: NFLIT_W];

   assign {cur_nf, cur_vc, cur_dest} = desc_mem[head];

   assign emit      = (state == ST_RUN) && !is_init && has_credit[cur_vc];
   assign is_tail   = flit_idx == (cur_nf - NFLIT_W'(1));
   assign last_pkt  = (sent + CNT_W'(1)) == total;
   assign head_wrap = ({1'b0, head} + (AW+1)'(1)) == fill_cnt;

   always_ff @(posedge clk) begin
      if (fill_ok)
         desc_mem[fill_cnt[AW-1:0]] <= {fill_nf, bus.data[DEST_W +: VC_W], bus.data[DEST_W-1:0]};
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
      assign credit_dec[v] = emit && (cur_vc == VC_W'(v));

      traffic_gen_credit_ctr #(
         .CREDIT_MAX (CREDIT_MAX)
      ) u_ctr (
         .clk        (clk),
         .rst        (rst),
         .clear      (is_init),
         .dec        (credit_dec[v]),
         .inc        (bus.credit_in[v]),
         .has_credit (has_credit[v]),
         .overflow   (credit_ovf[v])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         total          <= '0;
         sent           <= '0;
         fill_cnt       <= '0;
         head           <= '0;
         flit_idx       <= '0;
         bus.flit_valid <= 1'b0;
         bus.flit_data  <= '0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else if (is_init) begin
         // Abort from any state; an in-flight packet is simply abandoned without its tail.
         state          <= ST_LOAD;
         total          <= bus.data[DATA_W-1 -: CNT_W];
         sent           <= '0;
         fill_cnt       <= '0;
         head           <= '0;
         flit_idx       <= '0;
         bus.flit_valid <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.flit_valid <= 1'b0;
         if (|credit_ovf)
            bus.err <= 1'b1;
         if (is_fill) begin
            if (fill_ok)
               fill_cnt <= fill_cnt + (AW+1)'(1);
            else
               bus.err <= 1'b1;
         end

         case (state)
            ST_LOAD: begin
               if (is_start) begin
                  if (total == '0) begin
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                  end else if (fill_cnt == '0) begin
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (emit) begin
                  bus.flit_valid <= 1'b1;
                  bus.flit_data  <= {flit_idx == '0, is_tail, cur_vc,
                                     (flit_idx == '0) ? cur_dest : DEST_W'(flit_idx)};
                  if (is_tail) begin
                     flit_idx <= '0;
                     sent     <= sent + CNT_W'(1);
                     head     <= head_wrap ? '0 : head + AW'(1);
                     if (last_pkt) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                     end
                  end else begin
                     flit_idx <= flit_idx + NFLIT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TRAFFIC_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || is_init) begin
         stat_flits <= '0;
         stat_stall <= '0;
      end else begin
         if (emit && (stat_flits != '1))
            stat_flits <= stat_flits + 32'd1;
         if ((state == ST_RUN) && !has_credit[cur_vc] && (stat_stall != '1))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_traffic_gen.sv
// Randomized and directed checks of traffic_gen against a packet-level reference model.
module tb_traffic_gen;
   import traffic_gen_pkg::*;

   localparam int DEST_W     = 14;
   localparam int VC_W       = 2;
   localparam int NFLIT_W    = 10;
   localparam int DEPTH      = 8;
   localparam int CNT_W      = 10;
   localparam int DATA_W     = 32;
   localparam int CREDIT_MAX = 4;
   localparam int NUM_VC     = 1 << VC_W;
   localparam int FLIT_W     = 2 + VC_W + DEST_W;

   typedef struct {
      int dest;
      int vc;
      int nf;
   } desc_t;

   logic clk = 1'b0;
   logic rst;

   traffic_gen_if #(.DEST_W(DEST_W), .VC_W(VC_W), .DATA_W(DATA_W)) bus ();

`ifdef TRAFFIC_STATS_EN
   logic [31:0] stat_flits, stat_stall;
`endif

   traffic_gen #(
      .DEST_W     (DEST_W),
      .VC_W       (VC_W),
      .NFLIT_W    (NFLIT_W),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W),
      .DATA_W     (DATA_W),
      .CREDIT_MAX (CREDIT_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef TRAFFIC_STATS_EN
      ,
      .stat_flits (stat_flits),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                fcnt;
   int                outst [NUM_VC];
   desc_t             descs [$];
   logic [FLIT_W-1:0] expq  [$];
   logic [FLIT_W-1:0] last_flit;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [DATA_W-1:0] data);
      bus.op   = op;
      bus.data = data;
      tick();
      bus.op   = OP_NOP;
      bus.data = '0;
   endtask

   task automatic do_init(input int total);
      do_op(OP_INIT, DATA_W'(total) << (DATA_W - CNT_W));
      descs.delete();
      for (int v = 0; v < NUM_VC; v++) outst[v] = 0;
   endtask

   task automatic do_fill(input int dest, input int vc, input int nf);
      desc_t d;
      do_op(OP_FILL, (DATA_W'(nf) << (DEST_W + VC_W)) | (DATA_W'(vc) << DEST_W) | DATA_W'(dest));
      d.dest = dest;
      d.vc   = vc;
      d.nf   = nf;
      if (descs.size() < DEPTH) descs.push_back(d);
   endtask

   task automatic cyc(input logic [NUM_VC-1:0] cr);
      bus.credit_in = cr;
      tick();
      bus.credit_in = '0;
      if (bus.flit_valid) fcnt++;
   endtask

   function automatic logic [FLIT_W-1:0] make_flit(input bit h, input bit t, input int vc, input int f);
      logic [FLIT_W-1:0] r;
      r                  = '0;
      r[FLIT_W-1]        = h;
      r[FLIT_W-2]        = t;
      r[DEST_W +: VC_W]  = vc[VC_W-1:0];
      r[DEST_W-1:0]      = f[DEST_W-1:0];
      return r;
   endfunction

   // Packet k uses descriptor k mod count; flit 0 carries dest, flit i>0 carries i.
   function automatic void build_model(input int total);
      desc_t d;
      int    nf;
      expq.delete();
      for (int k = 0; k < total; k++) begin
         d  = descs[k % descs.size()];
         nf = (d.nf == 0) ? 1 : d.nf;
         for (int i = 0; i < nf; i++)
            expq.push_back(make_flit(i == 0, i == nf - 1, d.vc, (i == 0) ? d.dest : i));
      end
   endfunction

   // Downstream sink returns credits at random; flits are compared in order against the model.
   task automatic run_expect(input int budget, input int pct);
      int                cycles;
      bit                fin;
      int                v;
      logic [NUM_VC-1:0] cr;
      logic [FLIT_W-1:0] e;
      cycles = 0;
      fin    = 0;
      while (!fin && cycles < budget) begin
         cr = '0;
         for (int i = 0; i < NUM_VC; i++) begin
            if (outst[i] > 0 && $urandom_range(99) < pct) begin
               cr[i] = 1'b1;
               outst[i]--;
            end
         end
         bus.credit_in = cr;
         tick();
         bus.credit_in = '0;
         cycles++;
         if (bus.flit_valid) begin
            if (expq.size() == 0) begin
               check_eq("extra_flit", bus.flit_data, '0);
               fin = 1;
            end else begin
               e = expq.pop_front();
               last_flit = bus.flit_data;
               check_eq("flit", bus.flit_data, e);
               v = int'(e[DEST_W +: VC_W]);
               outst[v]++;
               check_eq("credit_bound", outst[v] <= CREDIT_MAX, 1);
               check_eq("done_on_tail", bus.done, expq.size() == 0);
               if (expq.size() == 0) fin = 1;
            end
         end
      end
      check_eq("flits_left", expq.size(), 0);
      repeat (3) tick();
      check_eq("quiet_after_done", bus.flit_valid, 0);
      check_eq("done_held", bus.done, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, tot;
      rst           = 1'b1;
      bus.op        = OP_NOP;
      bus.data      = '0;
      bus.credit_in = '0;
      repeat (2) tick();
      check_eq("rst_valid", bus.flit_valid, 0);
      check_eq("rst_data", bus.flit_data, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_err", bus.err, 0);
      rst = 1'b0;
      tick();

      // Single-flit packet.
      do_init(1);
      do_fill(5, 1, 1);
      do_op(OP_START, '0);
      build_model(1);
      run_expect(50, 100);
      check_eq("t1_flit", last_flit, make_flit(1, 1, 1, 5));

      // Two 3-flit packets.
      do_init(2);
      do_fill(9, 0, 3);
      do_op(OP_START, '0);
      build_model(2);
      run_expect(100, 100);

      // Credit exhaustion, single returns, then back-to-back return while emitting.
      do_init(1);
      do_fill(3, 0, 8);
      do_op(OP_START, '0);
      fcnt = 0;
      repeat (20) cyc('0);
      check_eq("t3_stall_count", fcnt, 4);
      cyc(4'b0001);
      repeat (5) cyc('0);
      cyc(4'b0001);
      repeat (5) cyc('0);
      check_eq("t3_two_more", fcnt, 6);
      cyc(4'b0001);
      cyc(4'b0001);
      repeat (5) cyc('0);
      check_eq("t3_simul_count", fcnt, 8);
      check_eq("t3_done", bus.done, 1);
      repeat (4) cyc(4'b0001);
      check_eq("t3_no_ovf", bus.err, 0);
      cyc(4'b0001);
      check_eq("t3_ovf_err", bus.err, 1);

      // Descriptor replay order A,B,A,B,A.
      do_init(5);
      do_fill(10, 0, 2);
      do_fill(20, 1, 1);
      do_op(OP_START, '0);
      build_model(5);
      run_expect(200, 60);

      // Overfill: extra FILL dropped, packet DEPTH+1 replays entry 0.
      do_init(DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) do_fill(100 + i, i % NUM_VC, 1);
      check_eq("t5_full_no_err", bus.err, 0);
      do_fill(999, 3, 2);
      check_eq("t5_overfill_err", bus.err, 1);
      do_op(OP_START, '0);
      build_model(DEPTH + 1);
      run_expect(300, 80);

      do_init(3);
      check_eq("t5_init_done_clr", bus.done, 0);
      check_eq("t5_init_err_clr", bus.err, 0);
      do_op(OP_START, '0);
      check_eq("t5_empty_done", bus.done, 1);
      check_eq("t5_empty_err", bus.err, 1);

      do_init(0);
      do_op(OP_START, '0);
      check_eq("t5_zero_done", bus.done, 1);
      check_eq("t5_zero_err", bus.err, 0);

      // Abort mid-packet with INIT, then confirm credits were restored.
      do_init(1);
      do_fill(7, 2, 5);
      do_op(OP_START, '0);
      fcnt = 0;
      for (int i = 0; i < 10 && fcnt < 2; i++) cyc('0);
      check_eq("t6_two_flits", fcnt, 2);
      do_init(1);
      check_eq("t6_abort_valid", bus.flit_valid, 0);
      check_eq("t6_abort_done", bus.done, 0);
      do_fill(7, 2, 5);
      do_op(OP_START, '0);
      fcnt = 0;
      repeat (20) cyc('0);
      check_eq("t6_credits_restored", fcnt, 4);

      // Reset while a flit is on the output.
      cyc(4'b0100);
      cyc('0);
      check_eq("t6_pre_rst_valid", bus.flit_valid, 1);
      rst = 1'b1;
      tick();
      check_eq("t6_rst_valid", bus.flit_valid, 0);
      check_eq("t6_rst_data", bus.flit_data, 0);
      check_eq("t6_rst_done", bus.done, 0);
      check_eq("t6_rst_err", bus.err, 0);
      rst = 1'b0;
      tick();
      do_fill(1, 0, 1);
      check_eq("fill_in_idle_err", bus.err, 1);

      // Randomized descriptor sets, totals and credit return rates.
      for (int it = 0; it < 25; it++) begin
         nd  = $urandom_range(1, DEPTH);
         tot = $urandom_range(1, 12);
         do_init(tot);
         for (int j = 0; j < nd; j++)
            do_fill($urandom_range(0, 16383), $urandom_range(0, NUM_VC - 1), $urandom_range(0, 6));
         do_op(OP_START, '0);
         build_model(tot);
         run_expect(4000, $urandom_range(10, 100));
         check_eq("rnd_err", bus.err, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
